// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the PC, issues one word per cycle to a 1-cycle imem, queues {instr, pc} for decode
module fetch_queue_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     ready_out,
    output logic [XLEN-1:0]          instr_out,
    output logic [XLEN-1:0]          pc_out,
    output logic [XLEN-1:0]          pc_4,
    output logic                     valid_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            has_head;
    logic            pop;
    // Issue credit counts the in-flight word so a response always finds room; head reads 0 when empty
    always_comb begin
        has_head  = count != '0;
        imem_req  = !reset && !redirect_valid && (count + CW'(inflight) < CW'(DEPTH));
        imem_addr = fetch_pc;
        valid_out = has_head && !redirect_valid;
        pop       = valid_out && ready_out;
        instr_out = has_head ? instr_q[rd_ptr] : '0;
        pc_out    = has_head ? pc_q[rd_ptr] : '0;
        pc_4      = has_head ? pc_q[rd_ptr] + XLEN'(4) : '0;
        count_out = count;
    end
    // PC, in-flight tracking and queue pointers; reset beats redirect, redirect beats handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + XLEN'(4);
                inflight_pc <= fetch_pc;
            end
            if (inflight) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end
    // Queue storage needs no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid && inflight) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: vector table, program-order scoreboard, random redirect soak and PC wrap check
module tb_fetch_queue_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        ready_out = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_4;
    logic        valid_out;
    logic [2:0]  count_out;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_p4;
    logic        w_valid;
    logic [2:0]  w_count;
    int checks = 0;
    int errors = 0;
    int hs = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t tbl [26];
    exp_t q [$];
    logic [31:0] nxt = '0;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ready_out(ready_out),
        .instr_out(instr_out), .pc_out(pc_out), .pc_4(pc_4), .valid_out(valid_out), .count_out(count_out)
    );

    fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata), .ready_out(1'b1),
        .instr_out(w_instr), .pc_out(w_pc), .pc_4(w_p4), .valid_out(w_valid), .count_out(w_count)
    );

    // Synchronous memories: requested word returns next cycle, garbage otherwise
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ K) : $urandom;
        w_rdata    <= w_req ? (w_addr ^ K) : $urandom;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic vec_t mk(input logic rs, input logic rd, input logic rr, input logic [31:0] rp,
                                input logic rq, input logic [31:0] ad, input logic vl,
                                input logic [31:0] pc, input logic [2:0] cn);
        vec_t v;
        v.rst = rs; v.rdy = rd; v.rdr = rr; v.rpc = rp;
        v.req = rq; v.addr = ad; v.vld = vl; v.pc = pc; v.cnt = cn;
        return v;
    endfunction

    // Program-order scoreboard: expected {pc, instr} queued from the restart point, popped per handshake
    always @(negedge clk) begin : sb
        exp_t e;
        if (reset) begin
            q.delete();
            nxt = 32'h0;
        end else if (redirect_valid) begin
            chk("redir_valid", 32'(valid_out), 32'd0);
            chk("redir_req", 32'(imem_req), 32'd0);
            q.delete();
            nxt = redirect_pc & ~32'h3;
        end else if (valid_out && ready_out) begin
            if (q.size() == 0) begin
                e.pc = nxt;
                e.instr = nxt ^ K;
                q.push_back(e);
                nxt += 32'd4;
            end
            e = q.pop_front();
            chk("sb_pc", pc_out, e.pc);
            chk("sb_instr", instr_out, e.instr);
            chk("sb_pc4", pc_4, e.pc + 32'd4);
            hs++;
        end
    end

    initial begin
        int gap;
        int hs0;
        logic [31:0] wp;
        tbl[0]  = mk(0, 1, 0, 32'h0,   1, 32'h000, 0, 32'h000, 3'd0);
        tbl[1]  = mk(0, 1, 0, 32'h0,   1, 32'h004, 0, 32'h000, 3'd0);
        tbl[2]  = mk(0, 1, 0, 32'h0,   1, 32'h008, 1, 32'h000, 3'd1);
        tbl[3]  = mk(0, 0, 0, 32'h0,   1, 32'h00C, 1, 32'h004, 3'd1);
        tbl[4]  = mk(0, 0, 0, 32'h0,   1, 32'h010, 1, 32'h004, 3'd2);
        tbl[5]  = mk(0, 0, 0, 32'h0,   0, 32'h014, 1, 32'h004, 3'd3);
        tbl[6]  = mk(0, 0, 0, 32'h0,   0, 32'h014, 1, 32'h004, 3'd4);
        tbl[7]  = mk(0, 0, 0, 32'h0,   0, 32'h014, 1, 32'h004, 3'd4);
        tbl[8]  = mk(0, 1, 0, 32'h0,   0, 32'h014, 1, 32'h004, 3'd4);
        tbl[9]  = mk(0, 1, 0, 32'h0,   1, 32'h014, 1, 32'h008, 3'd3);
        tbl[10] = mk(0, 1, 0, 32'h0,   1, 32'h018, 1, 32'h00C, 3'd2);
        tbl[11] = mk(0, 0, 0, 32'h0,   1, 32'h01C, 1, 32'h010, 3'd2);
        tbl[12] = mk(0, 1, 1, 32'h103, 0, 32'h020, 0, 32'h010, 3'd3);
        tbl[13] = mk(0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h000, 3'd0);
        tbl[14] = mk(0, 1, 0, 32'h0,   1, 32'h104, 0, 32'h000, 3'd0);
        tbl[15] = mk(0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100, 3'd1);
        tbl[16] = mk(0, 1, 1, 32'h200, 0, 32'h10C, 0, 32'h104, 3'd1);
        tbl[17] = mk(0, 1, 1, 32'h300, 0, 32'h200, 0, 32'h000, 3'd0);
        tbl[18] = mk(0, 1, 0, 32'h0,   1, 32'h300, 0, 32'h000, 3'd0);
        tbl[19] = mk(0, 1, 0, 32'h0,   1, 32'h304, 0, 32'h000, 3'd0);
        tbl[20] = mk(0, 1, 0, 32'h0,   1, 32'h308, 1, 32'h300, 3'd1);
        tbl[21] = mk(0, 0, 0, 32'h0,   1, 32'h30C, 1, 32'h304, 3'd1);
        tbl[22] = mk(1, 0, 0, 32'h0,   0, 32'h310, 1, 32'h304, 3'd2);
        tbl[23] = mk(0, 1, 0, 32'h0,   1, 32'h000, 0, 32'h000, 3'd0);
        tbl[24] = mk(0, 1, 0, 32'h0,   1, 32'h004, 0, 32'h000, 3'd0);
        tbl[25] = mk(0, 1, 0, 32'h0,   1, 32'h008, 1, 32'h000, 3'd1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 26; i++) begin
            reset = tbl[i].rst;
            ready_out = tbl[i].rdy;
            redirect_valid = tbl[i].rdr;
            redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(tbl[i].vld));
            chk($sformatf("v%0d_pc", i), pc_out, tbl[i].pc);
            chk($sformatf("v%0d_count", i), 32'(count_out), 32'(tbl[i].cnt));
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        gap = $urandom_range(5, 20);
        hs0 = hs;
        for (int c = 0; c < 10000; c++) begin
            ready_out = 1'($urandom_range(0, 1));
            redirect_valid = (gap == 0);
            if (gap == 0) begin
                redirect_pc = $urandom;
                gap = $urandom_range(5, 20);
            end else begin
                gap--;
            end
            @(negedge clk);
            chk("count_bound", 32'(count_out <= 3'd4), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("rand_progress", 32'((hs - hs0) > 1000), 32'd1);
        redirect_valid = 1'b0;
        ready_out = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("stream_valid", 32'(valid_out), 32'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            wp = 32'hFFFF_FFF8 + 32'(4 * k);
            @(negedge clk);
            chk("wrap_valid", 32'(w_valid), 32'd1);
            chk("wrap_pc", w_pc, wp);
            chk("wrap_pc4", w_p4, wp + 32'd4);
            chk("wrap_instr", w_instr, wp ^ K);
            @(posedge clk);
            #1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-entry fetch stage.
- Owns the PC register and issues one word per cycle to a 1-cycle-latency synchronous instruction memory.
- Buffers returned {instr, pc} pairs in a DEPTH-entry FIFO and presents the head to decode with a valid/ready handshake.
- Supports a redirect (branch/flush) input that squashes all buffered and in-flight fetches.

Parameters:
- XLEN, 32: width of PC and instruction words.
- DEPTH, 4: FIFO entries. Legal values are powers of two, 2..16; DEPTH >= 3 is required for 1 instr/cycle sustained throughput.
- RESET_PC, 32'h0000_0000: PC fetched first after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
- imem_req  out  1  memory read request this cycle
- imem_addr  out  XLEN  word-aligned read address
- imem_rdata  in  XLEN  read data, valid the cycle after imem_req
- ready_out  in  1  decode can accept this cycle
- instr_out  out  XLEN  head instruction
- pc_out  out  XLEN  head PC
- pc_4  out  XLEN  pc_out + 4, modulo 2^XLEN
- valid_out  out  1  head entry valid
- count_out  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sync, at clock edge): fetch_pc=RESET_PC, FIFO empty, count_out=0, inflight=0.
  - Resulting outputs: valid_out=0, imem_req=0; instr_out, pc_out and pc_4 read 0 while empty.
  - Reset overrides redirect and all handshakes; reset mid-stream discards everything.
- Issue:
  - imem_req = !reset && !redirect_valid && (count + inflight < DEPTH), using registered count and inflight.
  - imem_addr = fetch_pc.
  - On an issuing edge: fetch_pc += 4 (wraps modulo 2^XLEN), inflight_pc <= fetch_pc, inflight <= 1. A non-issuing edge clears inflight.
- Response: when inflight=1, imem_rdata is pushed with inflight_pc at the end of that cycle. The credit check guarantees no overflow, so a push never finds the FIFO full.
- Output and pop:
  - valid_out = (count != 0) && !redirect_valid.
  - Head is held stable while valid_out && !ready_out.
  - Pop when valid_out && ready_out.
  - Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- Latency: first valid_out is 2 cycles after the first imem_req.
  - Cycle 1 after reset release: req RESET_PC.
  - Cycle 2: data pushed.
  - Cycle 3: valid_out=1.
- Redirect: in the redirect_valid cycle, valid_out=0 (no handshake) and imem_req=0. At the edge:
  - FIFO cleared (count=0, pointers reset).
  - Any in-flight response is dropped (inflight=0; the next-cycle imem_rdata is ignored).
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - The next cycle issues redirect_pc.
  - Back-to-back redirects: the last one wins.
  - Redirect while empty is legal.
- Full: count + inflight == DEPTH suppresses issue until a pop. Issue resumes on the cycle after the pop edge; there is no same-cycle bypass.
- Empty with ready_out=1: no pop, and count never underflows.

Test Plan:
- Reset release, memory returns word = addr ^ 32'hA5A5_0000, ready_out=1 → valid_out rises 3rd cycle; pc_out 0,4,8,... on consecutive cycles with pc_4=pc_out+4; instr_out matches.
- ready_out=0 for 10 cycles (DEPTH=4) → count_out saturates at 4, imem_req=0 while count+inflight=4, head stays pc 0x0. Release → 4 pops in 4 cycles, then fetch resumes with no lost or duplicated PCs.
- redirect_valid=1, redirect_pc=32'h0000_0103 while count=3 and a fetch is in flight → valid_out=0 that cycle; count_out=0 next cycle; next imem_addr=0x100; next delivered pc_out=0x100, with no stale 0x0-series entries.
- RESET_PC=32'hFFFF_FFF8, free-running → pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_4 of FFFF_FFFC is 0.
- Random ready_out (50%) and random redirects every 5–20 cycles, 10k cycles, against a scoreboard model → delivered PC stream exactly matches a program-order model, with no handshake while redirect_valid=1.
- Assert reset for one cycle mid-stream with count=2 → count_out=0 and valid_out=0 the next cycle; fetch restarts at RESET_PC.
